// File: rtl/fir_cfg_regs.sv
// FIR-domain register bank behind the processor-to-FIR bridge.
// Define FIR_CFG_SHADOW_EN to double-buffer the coefficients behind a commit state machine.
module fir_cfg_regs #(
  parameter int N_TAPS = 32,
  parameter int DATA_W = 16
) (
  input  logic                     clk_b,
  input  logic                     rst_n,
  input  logic [5:0]               CDC_A,
  input  logic [DATA_W-1:0]        CDC_data,
  input  logic                     CDC_wr,
  output logic [DATA_W-1:0]        data_back,
  output logic [N_TAPS*DATA_W-1:0] coef_bus,
  output logic [5:0]               tap_count,
  output logic                     fir_en,
  output logic                     fir_start,
  input  logic                     fir_busy,
  input  logic                     fir_done,
  input  logic                     fir_ovf
);

  localparam int                IW       = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam logic [5:0]        NT6      = 6'(N_TAPS);
  localparam logic [DATA_W-1:0] NTW      = DATA_W'(N_TAPS);
  localparam logic [IW-1:0]     LAST_IDX = IW'(N_TAPS - 1);
  localparam logic [5:0]        A_CTRL   = 6'h20;
  localparam logic [5:0]        A_TAPS   = 6'h21;
  localparam logic [5:0]        A_STATUS = 6'h22;
  localparam logic [5:0]        A_DCNT   = 6'h23;
  localparam logic [5:0]        A_ID     = 6'h24;
  localparam logic [DATA_W-1:0] ID_VAL   = 16'hF1A0;

  function automatic logic [5:0] sat_taps(input logic [DATA_W-1:0] v);
    if (v == '0) begin
      return 6'd1;
    end else if (v > NTW) begin
      return NT6;
    end else begin
      return v[5:0];
    end
  endfunction

  logic                wr_prev_q, wr_prev_d;
  logic                wr_edge_s, coef_hit_s;
  logic [DATA_W-1:0]   act_q [N_TAPS];
  logic [DATA_W-1:0]   act_d [N_TAPS];
  logic [5:0]          taps_q, taps_d;
  logic                en_q, en_d, start_q, start_d;
  logic                done_q, done_d, ovf_q, ovf_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]   rd_s, data_back_q;
  logic                commit_busy_s, coef_drop_s;

`ifdef FIR_CFG_SHADOW_EN
  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_COPY = 1'b1} state_e;
  state_e              state_q, state_d;
  logic [DATA_W-1:0]   sh_q [N_TAPS];
  logic [DATA_W-1:0]   sh_d [N_TAPS];
  logic [IW-1:0]       idx_q, idx_d;
  logic                pend_q, pend_d, drop_q, drop_d;
  assign commit_busy_s = (state_q == ST_COPY);
  assign coef_drop_s   = drop_q;
`else
  assign commit_busy_s = 1'b0;
  assign coef_drop_s   = 1'b0;
`endif

  assign wr_edge_s  = CDC_wr & ~wr_prev_q;
  assign coef_hit_s = (CDC_A < NT6);

  // Write decode, sticky/counter updates and the commit copy engine.
  always_comb begin
    wr_prev_d = CDC_wr;
    act_d     = act_q;
    taps_d    = taps_q;
    en_d      = en_q;
    start_d   = 1'b0;
    done_d    = done_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
`ifdef FIR_CFG_SHADOW_EN
    sh_d      = sh_q;
    state_d   = state_q;
    idx_d     = idx_q;
    pend_d    = pend_q;
    drop_d    = drop_q;
`endif
    if (wr_edge_s && coef_hit_s) begin
`ifdef FIR_CFG_SHADOW_EN
      if (state_q == ST_COPY) begin
        drop_d = 1'b1;
      end else begin
        sh_d[CDC_A[IW-1:0]] = CDC_data;
      end
`else
      act_d[CDC_A[IW-1:0]] = CDC_data;
`endif
    end else if (wr_edge_s) begin
      case (CDC_A)
        A_CTRL: begin
          en_d = CDC_data[0];
`ifdef FIR_CFG_SHADOW_EN
          if (CDC_data[1] && (state_q == ST_COPY)) begin
            pend_d = 1'b1;
          end else begin
            start_d = CDC_data[1];
          end
          if (CDC_data[2] && (state_q == ST_IDLE)) begin
            state_d = ST_COPY;
            idx_d   = '0;
          end else begin
            state_d = state_q;
          end
`else
          start_d = CDC_data[1];
`endif
        end
        A_TAPS:   taps_d = sat_taps(CDC_data);
        A_STATUS: begin
          done_d = done_q & ~CDC_data[1];
          ovf_d  = ovf_q & ~CDC_data[2];
`ifdef FIR_CFG_SHADOW_EN
          drop_d = drop_q & ~CDC_data[4];
`endif
        end
        A_DCNT:   cnt_d = 16'h0000;
        default:  taps_d = taps_q;
      endcase
    end else begin
      wr_prev_d = CDC_wr;
    end
    // Pulses are applied after the write so a coincident set beats a clear.
    done_d = done_d | fir_done;
    ovf_d  = ovf_d | fir_ovf;
    cnt_d  = cnt_d + {15'd0, fir_done};
`ifdef FIR_CFG_SHADOW_EN
    if (state_q == ST_COPY) begin
      act_d[idx_q] = sh_q[idx_q];
      if (idx_q == LAST_IDX) begin
        state_d = ST_IDLE;
        idx_d   = '0;
        start_d = pend_d;
        pend_d  = 1'b0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else begin
      idx_d = idx_d;
    end
`endif
  end

  // Read mux for the address currently on the bus.
  always_comb begin
    rd_s = '0;
    if (coef_hit_s) begin
`ifdef FIR_CFG_SHADOW_EN
      rd_s = sh_q[CDC_A[IW-1:0]];
`else
      rd_s = act_q[CDC_A[IW-1:0]];
`endif
    end else begin
      case (CDC_A)
        A_CTRL:   rd_s = {15'd0, en_q};
        A_TAPS:   rd_s = {10'd0, taps_q};
        A_STATUS: rd_s = {11'd0, coef_drop_s, commit_busy_s, ovf_q, done_q, fir_busy};
        A_DCNT:   rd_s = cnt_q;
        A_ID:     rd_s = ID_VAL;
        default:  rd_s = 16'h0000;
      endcase
    end
  end

  // State registers; wr_prev tracks CDC_wr through reset so a held write is not replayed.
  always_ff @(posedge clk_b) begin
    if (!rst_n) begin
      wr_prev_q   <= CDC_wr;
      for (int i = 0; i < N_TAPS; i++) act_q[i] <= '0;
      taps_q      <= NT6;
      en_q        <= 1'b0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      cnt_q       <= 16'h0000;
      data_back_q <= 16'h0000;
`ifdef FIR_CFG_SHADOW_EN
      for (int i = 0; i < N_TAPS; i++) sh_q[i] <= '0;
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      pend_q      <= 1'b0;
      drop_q      <= 1'b0;
`endif
    end else begin
      wr_prev_q   <= wr_prev_d;
      act_q       <= act_d;
      taps_q      <= taps_d;
      en_q        <= en_d;
      start_q     <= start_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      data_back_q <= rd_s;
`ifdef FIR_CFG_SHADOW_EN
      sh_q        <= sh_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      drop_q      <= drop_d;
`endif
    end
  end

  for (genvar g = 0; g < N_TAPS; g++) begin : g_coef
    assign coef_bus[g*DATA_W +: DATA_W] = act_q[g];
  end

  assign data_back = data_back_q;
  assign tap_count = taps_q;
  assign fir_en    = en_q;
  assign fir_start = start_q;

endmodule

// File: tb/tb_fir_cfg_regs.sv
// Scoreboard bench for fir_cfg_regs: stimulus queues timestamped expectations, a negedge monitor checks them.
module tb_fir_cfg_regs;

`ifdef FIR_CFG_SHADOW_EN
  localparam bit SH = 1'b1;
`else
  localparam bit SH = 1'b0;
`endif

  localparam int K_RD = 0, K_COEF = 1, K_TAPS = 2, K_EN = 3, K_START = 4;

  logic          clk_b, rst_n, CDC_wr, fir_en, fir_start, fir_busy, fir_done, fir_ovf;
  logic [5:0]    CDC_A, tap_count;
  logic [15:0]   CDC_data, data_back;
  logic [511:0]  coef_bus;

  typedef struct {
    int          kind;
    int          idx;
    logic [15:0] exp;
    int          due;
  } sb_t;

  sb_t sb[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  t0;

  fir_cfg_regs #(.N_TAPS(32), .DATA_W(16)) dut (
    .clk_b(clk_b), .rst_n(rst_n), .CDC_A(CDC_A), .CDC_data(CDC_data), .CDC_wr(CDC_wr),
    .data_back(data_back), .coef_bus(coef_bus), .tap_count(tap_count), .fir_en(fir_en),
    .fir_start(fir_start), .fir_busy(fir_busy), .fir_done(fir_done), .fir_ovf(fir_ovf)
  );

  initial begin
    clk_b = 1'b0;
    forever #5 clk_b = ~clk_b;
  end

  always @(posedge clk_b) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_RD:    return "data_back";
      K_COEF:  return "coef";
      K_TAPS:  return "tap_count";
      K_EN:    return "fir_en";
      K_START: return "fir_start";
      default: return "unknown";
    endcase
  endfunction

  // Monitor: pops every expectation due this cycle and compares against the DUT.
  always @(negedge clk_b) begin
    logic [15:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        case (sb[i].kind)
          K_RD:    act = data_back;
          K_COEF:  act = coef_bus[sb[i].idx*16 +: 16];
          K_TAPS:  act = {10'd0, tap_count};
          K_EN:    act = {15'd0, fir_en};
          default: act = {15'd0, fir_start};
        endcase
        checks++;
        if (act !== sb[i].exp) begin
          errors++;
          $display("FAIL %s[%0d] cycle %0d: got %h expected %h",
                   kname(sb[i].kind), sb[i].idx, cyc, act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic tick;
    @(posedge clk_b);
    #1;
  endtask

  task automatic expect_at(input int kind, input int idx, input logic [15:0] exp, input int due);
    sb_t e;
    e.kind = kind; e.idx = idx; e.exp = exp; e.due = due;
    sb.push_back(e);
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] d);
    CDC_A = a; CDC_data = d; CDC_wr = 1'b1;
    tick;
    CDC_wr = 1'b0;
    tick;
  endtask

  task automatic rd(input logic [5:0] a, input logic [15:0] exp);
    CDC_A = a;
    expect_at(K_RD, 0, exp, cyc + 1);
    tick;
  endtask

  initial begin
    rst_n = 1'b0; CDC_wr = 1'b1; CDC_A = 6'h05; CDC_data = 16'h1234;
    fir_busy = 1'b0; fir_done = 1'b0; fir_ovf = 1'b0;

    // Reset held with a write asserted: nothing may commit.
    repeat (3) tick;
    expect_at(K_RD, 0, 16'h0000, cyc);
    expect_at(K_COEF, 5, 16'h0000, cyc);
    expect_at(K_TAPS, 0, 16'd32, cyc);
    expect_at(K_EN, 0, 16'h0000, cyc);
    expect_at(K_START, 0, 16'h0000, cyc);
    rst_n = 1'b1;
    expect_at(K_RD, 0, 16'h0000, cyc + 2);
    expect_at(K_COEF, 5, 16'h0000, cyc + 2);
    tick; tick;
    CDC_wr = 1'b0;
    tick;

    // One commit per rising edge of CDC_wr, even with data changing while held.
    t0 = cyc;
    CDC_A = 6'h05; CDC_data = 16'h1234; CDC_wr = 1'b1;
    expect_at(K_COEF, 5, 16'h0000, t0);
    expect_at(K_RD, 0, 16'h0000, t0 + 1);
    expect_at(K_COEF, 5, SH ? 16'h0000 : 16'h1234, t0 + 1);
    expect_at(K_RD, 0, 16'h1234, t0 + 2);
    tick; tick;
    CDC_data = 16'hBEEF;
    repeat (4) tick;
    expect_at(K_COEF, 5, SH ? 16'h0000 : 16'h1234, cyc);
    expect_at(K_RD, 0, 16'h1234, cyc);
    CDC_wr = 1'b0;
    tick;

    // TAPS saturation.
    wr(6'h21, 16'd0);
    expect_at(K_TAPS, 0, 16'd1, cyc);
    rd(6'h21, 16'd1);
    wr(6'h21, 16'd40);
    expect_at(K_TAPS, 0, 16'd32, cyc);
    wr(6'h21, 16'd8);
    rd(6'h21, 16'd8);

    // CTRL enable plus START pulse for exactly one cycle.
    t0 = cyc;
    CDC_A = 6'h20; CDC_data = 16'h0003; CDC_wr = 1'b1;
    expect_at(K_START, 0, 16'd0, t0);
    expect_at(K_START, 0, 16'd1, t0 + 1);
    expect_at(K_EN, 0, 16'd1, t0 + 1);
    expect_at(K_START, 0, 16'd0, t0 + 2);
    tick;
    CDC_wr = 1'b0;
    tick;
    rd(6'h20, 16'h0001);

    // Sticky bits, set-wins-over-clear, live busy.
    fir_done = 1'b1; tick; fir_done = 1'b0;
    rd(6'h22, 16'h0002);
    CDC_A = 6'h22; CDC_data = 16'h0002; CDC_wr = 1'b1; fir_done = 1'b1;
    tick;
    CDC_wr = 1'b0; fir_done = 1'b0;
    tick;
    rd(6'h22, 16'h0002);
    wr(6'h22, 16'h0002);
    rd(6'h22, 16'h0000);
    fir_ovf = 1'b1; tick; fir_ovf = 1'b0;
    fir_busy = 1'b1;
    rd(6'h22, 16'h0005);
    fir_busy = 1'b0;
    wr(6'h22, 16'h0004);
    rd(6'h22, 16'h0000);

    // DONE_CNT: coincident clear yields 1, then full wrap.
    rd(6'h23, 16'd2);
    CDC_A = 6'h23; CDC_data = 16'hFFFF; CDC_wr = 1'b1; fir_done = 1'b1;
    tick;
    CDC_wr = 1'b0; fir_done = 1'b0;
    tick;
    rd(6'h23, 16'd1);
    wr(6'h23, 16'h0000);
    rd(6'h23, 16'd0);
    fir_done = 1'b1;
    repeat (65535) tick;
    fir_done = 1'b0;
    rd(6'h23, 16'hFFFF);
    fir_done = 1'b1; tick; fir_done = 1'b0;
    rd(6'h23, 16'h0000);
    wr(6'h22, 16'h0002);
    rd(6'h22, 16'h0000);

    // ID, unmapped access, top coefficient.
    rd(6'h24, 16'hF1A0);
    wr(6'h3F, 16'hFFFF);
    rd(6'h3F, 16'h0000);
    rd(6'h25, 16'h0000);
    expect_at(K_TAPS, 0, 16'd8, cyc);
    expect_at(K_EN, 0, 16'd1, cyc);
    expect_at(K_COEF, 0, 16'h0000, cyc);
    rd(6'h20, 16'h0001);
    wr(6'h1F, 16'hA5A5);
    expect_at(K_COEF, 31, SH ? 16'h0000 : 16'hA5A5, cyc);
    rd(6'h1F, 16'hA5A5);

`ifdef FIR_CFG_SHADOW_EN
    // Commit with a dropped coefficient write and a deferred START.
    t0 = cyc;
    CDC_A = 6'h20; CDC_data = 16'h0005; CDC_wr = 1'b1;
    expect_at(K_RD, 0, 16'h0008, t0 + 2);
    expect_at(K_RD, 0, 16'h0018, t0 + 4);
    expect_at(K_START, 0, 16'd0, t0 + 5);
    expect_at(K_COEF, 5, 16'h0000, t0 + 6);
    expect_at(K_COEF, 5, 16'h1234, t0 + 7);
    expect_at(K_COEF, 31, 16'h0000, t0 + 32);
    expect_at(K_START, 0, 16'd0, t0 + 32);
    expect_at(K_COEF, 31, 16'hA5A5, t0 + 33);
    expect_at(K_START, 0, 16'd1, t0 + 33);
    expect_at(K_RD, 0, 16'h0018, t0 + 33);
    expect_at(K_START, 0, 16'd0, t0 + 34);
    expect_at(K_RD, 0, 16'h0010, t0 + 34);
    tick;
    CDC_wr = 1'b0; CDC_A = 6'h22;
    tick;
    CDC_A = 6'h02; CDC_data = 16'h7777; CDC_wr = 1'b1;
    tick;
    CDC_wr = 1'b0; CDC_A = 6'h22;
    tick;
    CDC_A = 6'h20; CDC_data = 16'h0003; CDC_wr = 1'b1;
    tick;
    CDC_wr = 1'b0; CDC_A = 6'h00;
    while (cyc < t0 + 32) tick;
    CDC_A = 6'h22;
    repeat (3) tick;
    rd(6'h02, 16'h0000);
    expect_at(K_COEF, 2, 16'h0000, cyc);
    wr(6'h22, 16'h0010);
    rd(6'h22, 16'h0000);
`else
    // COMMIT is inert without the shadow bank.
    wr(6'h20, 16'h0005);
    expect_at(K_EN, 0, 16'd1, cyc);
    expect_at(K_COEF, 5, 16'h1234, cyc);
    rd(6'h22, 16'h0000);
`endif

    repeat (3) tick;
    if (sb.size() != 0) begin
      checks++;
      errors += sb.size();
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
